data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Data-side bus responder that sits opposite the RV32I core's load/store port. It decodes the core's byte address, width code and write strobe, and serves two targets:
- a word-organised data RAM with byte/halfword lane steering and load sign/zero extension;
- a status register holding sticky access-error flags and a saturating store counter.

Reads are combinational, so the single-cycle core sees load data in the same cycle. Stores and status updates commit on the rising clock edge.

## Interface
Parameters:
- DEPTH_LOG2, 10: RAM depth is 2^DEPTH_LOG2 32-bit words (default 4 KiB).
- RAM_BASE, 32'h1000_0000: byte base of the RAM window. Aligned to the window size.
- STAT_ADDR, 32'h1000_F000: byte address of the status register. Word aligned, outside the RAM window.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = in reset).
- busAddr, input, 32: byte address from the core.
- busWData, input, 32: store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- busWe, input, 1: store strobe, sampled at the rising edge.
- func3, input, 3: access width code. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- busRData, output, 32: load data, combinational.
- busErr, output, 1: combinational; the current store is rejected.
- irq, output, 1: registered OR of the sticky status flags.

## Operation
- Decode:
  - ramHit when RAM_BASE <= busAddr < RAM_BASE + 4*2^DEPTH_LOG2.
  - statHit when busAddr == STAT_ADDR.
  - Otherwise the access is unmapped.
- RAM word index is busAddr[DEPTH_LOG2+1:2]. Byte offset is busAddr[1:0].
- Loads (every cycle, independent of busWe):
  - B/BU: byte at offset; sign-extended for B, zero-extended for BU.
  - H/HU: halfword at offset[1]; offset[0] is ignored.
  - W: full word; offset is ignored.
  - Reserved func3 (011, 110, 111) returns 0.
  - statHit returns the status word. Unmapped returns 0.
- Stores (busWe=1):
  - SB: writes the single lane busAddr[1:0] with busWData[7:0].
  - SH: legal only when busAddr[0]=0. Writes lanes {offset[1],0} and {offset[1],1} with busWData[15:0].
  - SW: legal only when busAddr[1:0]=0. Writes all 4 lanes.
  - func3 not in {000,001,010} is illegal.
- Rejection and flags:
  - Illegal width or misaligned RAM store: no lanes are written, busErr=1, status bit0 (MISALIGN) is set.
  - Unmapped store: busErr=1, status bit1 (UNMAPPED) is set.
  - Loads never set flags.
- Status word layout:
  - [0] MISALIGN, sticky.
  - [1] UNMAPPED, sticky.
  - [15:2] read as 0.
  - [31:16] STORE_CNT: count of successful RAM stores, saturating at 16'hFFFF.
- Status store: only SW is accepted. SB/SH to STAT_ADDR is a misaligned store: sets MISALIGN and busErr.
  - wdata[0]=1 clears MISALIGN; wdata[1]=1 clears UNMAPPED (write-1-to-clear).
  - wdata[2]=1 clears STORE_CNT.
  - A legal status store is not counted.
- Successful RAM store: STORE_CNT increments by 1 unless it is already 16'hFFFF.
- irq register is loaded each edge with the next-state MISALIGN | UNMAPPED.

## Timing
- Reset (reset=0, asynchronous):
  - MISALIGN, UNMAPPED, STORE_CNT and irq go to 0 immediately.
  - RAM contents are not reset and are undefined until written.
  - busRData and busErr remain combinational; status reads return 0.
  - RAM and status writes are blocked while reset=0.
- Release: the first edge with reset=1 may commit a store.
- Store latency: data is visible on busRData in the cycle after the committing edge. The same-cycle read returns old data (read-before-write).
- Flag set: visible in status reads and on irq from the cycle after the offending edge.
- Simultaneous set and clear: only one access occurs per cycle, so a W1C status store cannot coincide with an error from another access. A rejected SB/SH to STAT_ADDR sets MISALIGN and clears nothing.
- STORE_CNT at 16'hFFFF: a further successful store leaves it at 16'hFFFF; the store itself is still performed.
- reset=0 mid-cycle while busWe=1: the store is lost and the flags are cleared.

## Test plan
- Word store and loads:
  - SW 32'h8899_AABB to RAM_BASE+8, then LW at RAM_BASE+8 -> 32'h8899_AABB.
  - LB at RAM_BASE+9 -> 32'hFFFF_FFAA.
  - LBU at RAM_BASE+9 -> 32'h0000_00AA.
  - LH at RAM_BASE+10 -> 32'hFFFF_8899.
  - LHU at RAM_BASE+10 -> 32'h0000_8899.
- Lane steering:
  - From 32'h8899_AABB at RAM_BASE+8, SB 8'h11 to RAM_BASE+11, then LW -> 32'h1199_AABB.
  - Then SH 16'h2233 to RAM_BASE+8, then LW -> 32'h1199_2233.
- Misaligned rejection:
  - SW to RAM_BASE+6 (data 32'h1234_5678) -> busErr=1 that cycle.
  - Word at RAM_BASE+4 unchanged.
  - Status reads 32'h0000_0001; irq=1 next cycle.
  - SW 32'h1 to STAT_ADDR -> status 0, irq=0.
- Unmapped and reserved:
  - SW to 32'h2000_0000 -> UNMAPPED set, busErr=1.
  - LW from 32'h2000_0000 -> 0, with no flag change.
  - SB with func3=3'b011 to RAM_BASE -> MISALIGN set, RAM unchanged.
- Counter:
  - 3 legal stores -> status[31:16]=3.
  - SW 32'h4 to STAT_ADDR -> status[31:16]=0.
  - Force 65,536 stores -> counter holds at 16'hFFFF.
- Asynchronous reset:
  - Set both flags, then drive reset=0 between edges -> irq and status read 0 immediately.
  - SW with busWe=1 while reset=0 does not modify RAM.

Source files
------------

// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_responder
// Brief    : RV32I data-port responder serving a byte-lane RAM and a status
//            register with sticky error flags and a saturating store counter.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] RAM_BASE   = 32'h1000_0000,
    parameter logic [31:0] STAT_ADDR  = 32'h1000_F000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    input  logic        busWe,
    input  logic [2:0]  func3,
    output logic [31:0] busRData,
    output logic        busErr,
    output logic        irq
);

    localparam int          c_depth  = 1 << DEPTH_LOG2;
    localparam logic [32:0] c_ram_lo = {1'b0, RAM_BASE};
    localparam logic [32:0] c_ram_hi = c_ram_lo + (33'd4 << DEPTH_LOG2);

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    logic [31:0] r_mem [0:c_depth-1];
    logic        r_misalign;
    logic        r_unmapped;
    logic [15:0] r_store_cnt;

    logic                  w_ram_hit;
    logic                  w_stat_hit;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [1:0]            w_off;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ram_rdata;
    logic [31:0]           w_status;
    logic                  w_store_ok;
    logic [3:0]            w_be;
    logic [31:0]           w_wlanes;
    logic                  w_ram_we;
    logic                  w_misalign_nxt;
    logic                  w_unmapped_nxt;
    logic [15:0]           w_cnt_nxt;

    assign w_ram_hit  = ({1'b0, busAddr} >= c_ram_lo) && ({1'b0, busAddr} < c_ram_hi);
    assign w_stat_hit = (busAddr == STAT_ADDR);
    assign w_idx      = busAddr[DEPTH_LOG2+1:2];
    assign w_off      = busAddr[1:0];
    assign w_status   = {r_store_cnt, 14'd0, r_unmapped, r_misalign};

    // Read path is combinational so the single-cycle core sees data in-cycle.
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[8*w_off +: 8];
    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_ram_rdata = 32'd0;
        case (func3)
            c_f3_b:  w_ram_rdata = {{24{w_byte[7]}}, w_byte};
            c_f3_bu: w_ram_rdata = {24'd0, w_byte};
            c_f3_h:  w_ram_rdata = {{16{w_half[15]}}, w_half};
            c_f3_hu: w_ram_rdata = {16'd0, w_half};
            c_f3_w:  w_ram_rdata = w_word;
            default: w_ram_rdata = 32'd0;
        endcase
    end

    assign busRData = w_ram_hit  ? w_ram_rdata :
                      w_stat_hit ? w_status    : 32'd0;

    // Lane enables and replicated write data for the legal store widths.
    always_comb begin
        w_store_ok = 1'b0;
        w_be       = 4'b0000;
        w_wlanes   = busWData;
        case (func3)
            c_f3_b: begin
                w_store_ok = 1'b1;
                w_be       = 4'b0001 << w_off;
                w_wlanes   = {4{busWData[7:0]}};
            end
            c_f3_h: begin
                w_store_ok = ~w_off[0];
                w_be       = w_off[1] ? 4'b1100 : 4'b0011;
                w_wlanes   = {2{busWData[15:0]}};
            end
            c_f3_w: begin
                w_store_ok = (w_off == 2'b00);
                w_be       = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_misalign_nxt = r_misalign;
        w_unmapped_nxt = r_unmapped;
        w_cnt_nxt      = r_store_cnt;
        w_ram_we       = 1'b0;
        busErr         = 1'b0;
        if (busWe) begin
            if (w_ram_hit) begin
                if (w_store_ok) begin
                    w_ram_we = 1'b1;
                    if (r_store_cnt != 16'hFFFF)
                        w_cnt_nxt = r_store_cnt + 16'd1;
                end else begin
                    busErr         = 1'b1;
                    w_misalign_nxt = 1'b1;
                end
            end else if (w_stat_hit) begin
                if (func3 == c_f3_w) begin
                    if (busWData[0]) w_misalign_nxt = 1'b0;
                    if (busWData[1]) w_unmapped_nxt = 1'b0;
                    if (busWData[2]) w_cnt_nxt      = 16'd0;
                end else begin
                    busErr         = 1'b1;
                    w_misalign_nxt = 1'b1;
                end
            end else begin
                busErr         = 1'b1;
                w_unmapped_nxt = 1'b1;
            end
        end
    end

    // RAM is not reset; the reset level only blocks writes.
    always_ff @(posedge clk) begin
        if (reset && w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign  <= 1'b0;
            r_unmapped  <= 1'b0;
            r_store_cnt <= 16'd0;
            irq         <= 1'b0;
        end else begin
            r_misalign  <= w_misalign_nxt;
            r_unmapped  <= w_unmapped_nxt;
            r_store_cnt <= w_cnt_nxt;
            irq         <= w_misalign_nxt | w_unmapped_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_responder
// Brief    : Directed self-checking bench; load results go through a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_responder;

    localparam logic [31:0] RB = 32'h1000_0000;
    localparam logic [31:0] SA = 32'h1000_F000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] busAddr = 32'd0;
    logic [31:0] busWData = 32'd0;
    logic        busWe = 1'b0;
    logic [2:0]  func3 = 3'b010;
    logic [31:0] busRData;
    logic        busErr;
    logic        irq;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    data_bus_responder dut (
        .clk      (clk),
        .reset    (reset),
        .busAddr  (busAddr),
        .busWData (busWData),
        .busWe    (busWe),
        .func3    (func3),
        .busRData (busRData),
        .busErr   (busErr),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drives a load, queues the expected result, compares before the next edge.
    task automatic load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] exp);
        exp_t e;
        busWe   = 1'b0;
        busAddr = a;
        func3   = f3;
        e.tag   = tag;
        e.val   = exp;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk(e.tag, busRData, e.val);
        @(posedge clk);
        #1;
    endtask

    task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input logic exp_err);
        busAddr  = a;
        busWData = d;
        func3    = f3;
        busWe    = 1'b1;
        @(negedge clk);
        chk({tag, "_err"}, {31'd0, busErr}, {31'd0, exp_err});
        @(posedge clk);
        #1;
        busWe = 1'b0;
    endtask

    initial begin
        // Held in reset: status and irq read zero.
        #2;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        busAddr = SA;
        #1;
        chk("rst_status", busRData, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        store("sw8", RB + 8, 32'h8899_AABB, 3'b010, 1'b0);
        load("lw8",   RB + 8,  3'b010, 32'h8899_AABB);
        load("lb9",   RB + 9,  3'b000, 32'hFFFF_FFAA);
        load("lbu9",  RB + 9,  3'b100, 32'h0000_00AA);
        load("lh10",  RB + 10, 3'b001, 32'hFFFF_8899);
        load("lhu10", RB + 10, 3'b101, 32'h0000_8899);

        store("sb11", RB + 11, 32'h0000_0011, 3'b000, 1'b0);
        load("lw_sb", RB + 8, 3'b010, 32'h1199_AABB);
        store("sh8", RB + 8, 32'h0000_2233, 3'b001, 1'b0);
        load("lw_sh", RB + 8, 3'b010, 32'h1199_2233);
        load("lh11",  RB + 11, 3'b001, 32'h0000_1199);
        load("cnt3",  SA, 3'b010, 32'h0003_0000);

        store("sw4", RB + 4, 32'hCAFE_F00D, 3'b010, 1'b0);
        load("cnt4", SA, 3'b010, 32'h0004_0000);
        store("clr_cnt", SA, 32'h4, 3'b010, 1'b0);
        load("cnt_clr", SA, 3'b010, 32'h0000_0000);

        store("sw_mis", RB + 6, 32'h1234_5678, 3'b010, 1'b1);
        chk("irq_mis", {31'd0, irq}, 32'd1);
        load("lw4_keep", RB + 4, 3'b010, 32'hCAFE_F00D);
        load("st_mis", SA, 3'b010, 32'h0000_0001);
        load("rsv_load", RB + 4, 3'b011, 32'h0000_0000);
        store("w1c_mis", SA, 32'h1, 3'b010, 1'b0);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        load("st_clr", SA, 3'b010, 32'h0000_0000);

        store("sw_unm", 32'h2000_0000, 32'h1, 3'b010, 1'b1);
        chk("irq_unm", {31'd0, irq}, 32'd1);
        load("lw_unm", 32'h2000_0000, 3'b010, 32'h0000_0000);
        load("st_unm", SA, 3'b010, 32'h0000_0002);

        store("sw_base", RB, 32'h55AA_55AA, 3'b010, 1'b0);
        store("sb_rsv", RB, 32'h0000_00FF, 3'b011, 1'b1);
        store("sh_odd", RB + 1, 32'h0000_FFFF, 3'b001, 1'b1);
        load("lw_base", RB, 3'b010, 32'h55AA_55AA);
        load("st_both", SA, 3'b010, 32'h0001_0003);
        store("w1c_both", SA, 32'h3, 3'b010, 1'b0);
        store("sh_stat", SA, 32'h3, 3'b001, 1'b1);
        load("st_shstat", SA, 3'b010, 32'h0001_0001);

        // Drive the counter to saturation and one store beyond.
        store("clr_cnt2", SA, 32'h4, 3'b010, 1'b0);
        busAddr = RB + 32'h20;
        func3   = 3'b010;
        busWe   = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            busWData = i;
            @(posedge clk);
        end
        #1;
        busWe = 1'b0;
        load("cnt_ffff", SA, 3'b010, 32'hFFFF_0001);
        store("sw_sat", RB + 32'h20, 32'hDEAD_BEEF, 3'b010, 1'b0);
        load("cnt_hold", SA, 3'b010, 32'hFFFF_0001);
        load("lw_sat", RB + 32'h20, 3'b010, 32'hDEAD_BEEF);

        // Asynchronous reset between edges, with a store pending.
        store("sw_unm2", 32'h3000_0000, 32'h0, 3'b010, 1'b1);
        load("st_pre", SA, 3'b010, 32'hFFFF_0003);
        chk("irq_pre", {31'd0, irq}, 32'd1);
        busAddr  = RB + 8;
        busWData = 32'h0BAD_F00D;
        func3    = 3'b010;
        busWe    = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("arst_irq", {31'd0, irq}, 32'd0);
        busWe   = 1'b0;
        busAddr = SA;
        #1;
        chk("arst_status", busRData, 32'd0);
        busAddr = RB + 8;
        busWe   = 1'b1;
        @(posedge clk);
        #1;
        busWe = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        load("lw_rst_keep", RB + 8, 3'b010, 32'h1199_2233);
        store("sw_post", RB + 12, 32'h0000_0777, 3'b010, 1'b0);
        load("lw_post", RB + 12, 3'b010, 32'h0000_0777);
        load("st_post", SA, 3'b010, 32'h0001_0000);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
